// File: rtl/sonar_pkg.sv
// Shared types, default parameters and channel-selection helper for the sonar scheduler.
package sonar_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_TRIG,
        ST_WAIT_RISE,
        ST_MEASURE,
        ST_HOLDOFF
    } state_t;

    localparam int DEF_N_SENSORS      = 4;
    localparam int DEF_WIDTH          = 8;
    localparam int DEF_TRIG_CYCLES    = 2;
    localparam int DEF_RISE_TIMEOUT   = 50;
    localparam int DEF_HOLDOFF_CYCLES = 600;
    localparam int MAX_SENSORS        = 8;

    // Lowest enabled index strictly above cur; -1 when none. cur=-1 yields the lowest enabled.
    function automatic int next_enabled(input int cur, input logic [MAX_SENSORS-1:0] mask);
        int r;
        r = -1;
        for (int i = MAX_SENSORS - 1; i >= 0; i--) begin
            if (i > cur && mask[i]) r = i;
        end
        return r;
    endfunction

endpackage

// File: rtl/sonar_satcnt.sv
// WIDTH-bit up-counter with synchronous clear and enable that sticks at all-ones.
module sonar_satcnt #(
    parameter int WIDTH = 8
) (
    input  logic             clock,
    input  logic             resetN,
    input  logic             clr,
    input  logic             en,
    output logic [WIDTH-1:0] cnt,
    output logic             sat
);

    assign sat = &cnt;

    always_ff @(posedge clock or negedge resetN) begin
        if (!resetN)          cnt <= '0;
        else if (clr)         cnt <= '0;
        else if (en && !sat)  cnt <= cnt + 1'b1;
    end

endmodule

// File: rtl/sonar_scheduler.sv
// Round-robin trigger/echo-timing sequencer for N ultrasonic sensors sharing one counter.
// Build option: define SONAR_SCHED_SYNC_EN to add a two-flop synchronizer on every sEcho bit.
//
// state      | meaning
// IDLE       | waiting for start with a non-empty enable mask
// TRIG       | driving sTrigger[id] for TRIG_CYCLES cycles
// WAIT_RISE  | waiting up to RISE_TIMEOUT cycles for the echo to go high
// MEASURE    | counting echo high time, publish on fall or saturation
// HOLDOFF    | HOLDOFF_CYCLES quiet cycles, then next enabled channel
module sonar_scheduler
    import sonar_pkg::*;
#(
    parameter int N_SENSORS      = DEF_N_SENSORS,
    parameter int WIDTH          = DEF_WIDTH,
    parameter int TRIG_CYCLES    = DEF_TRIG_CYCLES,
    parameter int RISE_TIMEOUT   = DEF_RISE_TIMEOUT,
    parameter int HOLDOFF_CYCLES = DEF_HOLDOFF_CYCLES
) (
    input  logic                         clock,
    input  logic                         resetN,
    input  logic                         start,
    input  logic                         continuous,
    input  logic [N_SENSORS-1:0]         enMask,
    input  logic [N_SENSORS-1:0]         sEcho,
    output logic [N_SENSORS-1:0]         sTrigger,
    output logic [WIDTH-1:0]             meas,
    output logic [$clog2(N_SENSORS)-1:0] measId,
    output logic                         measValid,
    output logic                         measTimeout,
    output logic                         measSat,
    output logic                         busy
);

    localparam int ID_W    = $clog2(N_SENSORS);
    localparam int TMR_MAX = (HOLDOFF_CYCLES > RISE_TIMEOUT)
                           ? ((HOLDOFF_CYCLES > TRIG_CYCLES) ? HOLDOFF_CYCLES : TRIG_CYCLES)
                           : ((RISE_TIMEOUT > TRIG_CYCLES) ? RISE_TIMEOUT : TRIG_CYCLES);
    localparam int TMR_W   = $clog2(TMR_MAX + 1);
    localparam logic [N_SENSORS-1:0] ONE_HOT0 = N_SENSORS'(1);

    logic [N_SENSORS-1:0]   echo_s;
    state_t                 state;
    logic [ID_W-1:0]        id;
    logic [TMR_W-1:0]       tmr;
    logic [MAX_SENSORS-1:0] mask_ext;
    int                     nxt_above;
    int                     nxt_low;
    logic                   echo;
    logic                   cnt_clr;
    logic                   cnt_en;
    logic [WIDTH-1:0]       cnt;
    logic                   cnt_sat;

`ifdef SONAR_SCHED_SYNC_EN
    logic [N_SENSORS-1:0] echo_m;

    always_ff @(posedge clock or negedge resetN) begin
        if (!resetN) begin
            echo_m <= '0;
            echo_s <= '0;
        end else begin
            echo_m <= sEcho;
            echo_s <= echo_m;
        end
    end
`else
    assign echo_s = sEcho;
`endif

    always_comb begin
        mask_ext                = '0;
        mask_ext[N_SENSORS-1:0] = enMask;
        nxt_above               = next_enabled(int'(id), mask_ext);
        nxt_low                 = next_enabled(-1, mask_ext);
    end

    assign echo    = echo_s[id];
    assign busy    = (state != ST_IDLE);
    assign cnt_clr = (state == ST_IDLE) || (state == ST_TRIG) || (state == ST_HOLDOFF);
    assign cnt_en  = echo && ((state == ST_WAIT_RISE) || (state == ST_MEASURE));

    // The rise edge in WAIT_RISE already counts as the first high cycle.
    sonar_satcnt #(.WIDTH(WIDTH)) u_echo_cnt (
        .clock  (clock),
        .resetN (resetN),
        .clr    (cnt_clr),
        .en     (cnt_en),
        .cnt    (cnt),
        .sat    (cnt_sat)
    );

    always_ff @(posedge clock or negedge resetN) begin
        if (!resetN) begin
            state       <= ST_IDLE;
            id          <= '0;
            tmr         <= '0;
            sTrigger    <= '0;
            meas        <= '0;
            measId      <= '0;
            measValid   <= 1'b0;
            measTimeout <= 1'b0;
            measSat     <= 1'b0;
        end else begin
            measValid <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start && (enMask != '0)) begin
                        id       <= ID_W'(nxt_low);
                        sTrigger <= ONE_HOT0 << ID_W'(nxt_low);
                        tmr      <= TMR_W'(TRIG_CYCLES - 1);
                        state    <= ST_TRIG;
                    end
                end
                ST_TRIG: begin
                    if (tmr == '0) begin
                        sTrigger <= '0;
                        tmr      <= TMR_W'(RISE_TIMEOUT - 1);
                        state    <= ST_WAIT_RISE;
                    end else begin
                        tmr <= tmr - 1'b1;
                    end
                end
                ST_WAIT_RISE: begin
                    if (echo) begin
                        state <= ST_MEASURE;
                    end else if (tmr == '0) begin
                        meas        <= '0;
                        measId      <= id;
                        measTimeout <= 1'b1;
                        measSat     <= 1'b0;
                        measValid   <= 1'b1;
                        tmr         <= TMR_W'(HOLDOFF_CYCLES - 1);
                        state       <= ST_HOLDOFF;
                    end else begin
                        tmr <= tmr - 1'b1;
                    end
                end
                ST_MEASURE: begin
                    if (!echo || cnt_sat) begin
                        meas        <= cnt;
                        measId      <= id;
                        measTimeout <= 1'b0;
                        measSat     <= echo;
                        measValid   <= 1'b1;
                        tmr         <= TMR_W'(HOLDOFF_CYCLES - 1);
                        state       <= ST_HOLDOFF;
                    end
                end
                ST_HOLDOFF: begin
                    if (tmr != '0) begin
                        tmr <= tmr - 1'b1;
                    end else if (nxt_above >= 0) begin
                        id       <= ID_W'(nxt_above);
                        sTrigger <= ONE_HOT0 << ID_W'(nxt_above);
                        tmr      <= TMR_W'(TRIG_CYCLES - 1);
                        state    <= ST_TRIG;
                    end else if (continuous && (enMask != '0)) begin
                        id       <= ID_W'(nxt_low);
                        sTrigger <= ONE_HOT0 << ID_W'(nxt_low);
                        tmr      <= TMR_W'(TRIG_CYCLES - 1);
                        state    <= ST_TRIG;
                    end else begin
                        state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sonar_scheduler.sv
// Self-checking bench for sonar_scheduler: sensor emulator, result monitor and sweep-level reference model.
module tb_sonar_scheduler;

    localparam int N = 4;
    localparam int W = 8;
    localparam int T = 2;
    localparam int R = 50;
    localparam int H = 600;
`ifdef SONAR_SCHED_SYNC_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 0;
`endif

    logic         clock = 1'b0;
    logic         resetN = 1'b0;
    logic         start = 1'b0;
    logic         continuous = 1'b0;
    logic [N-1:0] enMask = '0;
    logic [N-1:0] sEcho = '0;
    logic [N-1:0] sTrigger;
    logic [W-1:0] meas;
    logic [1:0]   measId;
    logic         measValid, measTimeout, measSat, busy;

    sonar_scheduler #(
        .N_SENSORS(N), .WIDTH(W), .TRIG_CYCLES(T), .RISE_TIMEOUT(R), .HOLDOFF_CYCLES(H)
    ) dut (
        .clock(clock), .resetN(resetN), .start(start), .continuous(continuous),
        .enMask(enMask), .sEcho(sEcho), .sTrigger(sTrigger), .meas(meas),
        .measId(measId), .measValid(measValid), .measTimeout(measTimeout),
        .measSat(measSat), .busy(busy)
    );

    always #5 clock = ~clock;

    typedef struct {
        int id;
        int meas;
        int to;
        int sat;
        int cyc;
    } rec_t;

    rec_t         got[$];
    int           len_cfg[N];
    int           dly_cfg[N];
    int           rem[N], dly[N];
    bit           echo_hi[N], pending[N];
    int           rise_cyc[N], fall_cyc[N], trig_rise_cyc[N], trig_w[N];
    logic [N-1:0] trig_prev = '0;
    logic [N-1:0] trig_seen = '0;
    int           cyc = 0;
    int           checks = 0;
    int           errors = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
        end
    endtask

    // Sensor emulator and result monitor, both sampled away from the active edge.
    initial forever begin
        @(negedge clock);
        cyc++;
        if (!resetN) begin
            sEcho     = '0;
            trig_prev = '0;
            for (int i = 0; i < N; i++) begin
                echo_hi[i] = 1'b0;
                pending[i] = 1'b0;
                trig_w[i]  = 0;
            end
        end else begin
            for (int i = 0; i < N; i++) begin
                if (echo_hi[i]) begin
                    rem[i]--;
                    if (rem[i] == 0) begin
                        sEcho[i]    = 1'b0;
                        echo_hi[i]  = 1'b0;
                        fall_cyc[i] = cyc;
                    end
                end else if (pending[i]) begin
                    if (dly[i] == 0) begin
                        sEcho[i]    = 1'b1;
                        echo_hi[i]  = 1'b1;
                        rem[i]      = len_cfg[i];
                        rise_cyc[i] = cyc;
                        pending[i]  = 1'b0;
                    end else begin
                        dly[i]--;
                    end
                end
                if (sTrigger[i] && !trig_prev[i]) begin
                    trig_rise_cyc[i] = cyc;
                    trig_w[i]        = 0;
                    chk($sformatf("trig onehot ch%0d", i), sTrigger, 32'(1) << i);
                end
                if (sTrigger[i]) trig_w[i]++;
                if (!sTrigger[i] && trig_prev[i]) begin
                    chk($sformatf("trig width ch%0d", i), trig_w[i], T);
                    if (len_cfg[i] > 0) begin
                        pending[i] = 1'b1;
                        dly[i]     = dly_cfg[i];
                    end
                end
            end
            trig_prev = sTrigger;
            trig_seen = trig_seen | sTrigger;
            if (measValid) begin
                rec_t r;
                r.id   = int'(measId);
                r.meas = int'(meas);
                r.to   = int'(measTimeout);
                r.sat  = int'(measSat);
                r.cyc  = cyc;
                got.push_back(r);
                if (r.to == 1)
                    chk($sformatf("timeout latency ch%0d", r.id), r.cyc - trig_rise_cyc[r.id], T + R);
                else if (r.sat == 1)
                    chk($sformatf("sat latency ch%0d", r.id), r.cyc - rise_cyc[r.id], (1 << W) + LAT);
                else
                    chk($sformatf("fall latency ch%0d", r.id), r.cyc - fall_cyc[r.id], LAT + 1);
            end
        end
    end

    // Reference model: one result per enabled channel, ascending index.
    task automatic build_expected(input logic [N-1:0] mask, output rec_t e[$]);
        e.delete();
        for (int i = 0; i < N; i++) begin
            if (mask[i]) begin
                rec_t r;
                r.id  = i;
                r.cyc = 0;
                if (len_cfg[i] == 0) begin
                    r.meas = 0; r.to = 1; r.sat = 0;
                end else if (len_cfg[i] > (1 << W) - 1) begin
                    r.meas = (1 << W) - 1; r.to = 0; r.sat = 1;
                end else begin
                    r.meas = len_cfg[i]; r.to = 0; r.sat = 0;
                end
                e.push_back(r);
            end
        end
    endtask

    task automatic check_results(input logic [N-1:0] mask, input int reps, input string tag);
        rec_t e[$];
        int   j;
        build_expected(mask, e);
        chk({tag, " count"}, got.size(), e.size() * reps);
        for (int k = 0; k < got.size() && k < e.size() * reps; k++) begin
            j = k % e.size();
            chk($sformatf("%s id[%0d]", tag, k), got[k].id, e[j].id);
            chk($sformatf("%s meas[%0d]", tag, k), got[k].meas, e[j].meas);
            chk($sformatf("%s timeout[%0d]", tag, k), got[k].to, e[j].to);
            chk($sformatf("%s sat[%0d]", tag, k), got[k].sat, e[j].sat);
        end
    endtask

    task automatic do_start(input logic [N-1:0] mask, input string tag);
        int low;
        low = -1;
        for (int i = N - 1; i >= 0; i--) if (mask[i]) low = i;
        enMask = mask;
        @(negedge clock);
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        chk({tag, " busy after start"}, busy, 1);
        chk({tag, " first trigger"}, sTrigger, 32'(1) << low);
    endtask

    task automatic wait_idle(input int max_cyc, input string tag);
        int n;
        n = 0;
        while (busy !== 1'b0 && n < max_cyc) begin
            @(negedge clock);
            n++;
        end
        chk({tag, " returns idle"}, busy, 0);
    endtask

    task automatic wait_strobes(input int cnt, input int max_cyc, input string tag);
        int n;
        n = 0;
        while (got.size() < cnt && n < max_cyc) begin
            @(negedge clock);
            n++;
        end
        chk({tag, " strobes reached"}, got.size() >= cnt, 1);
    endtask

    task automatic run_sweep(input logic [N-1:0] mask, input string tag);
        got.delete();
        do_start(mask, tag);
        wait_idle(10000, tag);
        check_results(mask, 1, tag);
    endtask

    initial begin
        for (int i = 0; i < N; i++) begin
            len_cfg[i] = 10 * (i + 1);
            dly_cfg[i] = 0;
        end
        repeat (3) @(negedge clock);
        chk("reset sTrigger", sTrigger, 0);
        chk("reset meas", meas, 0);
        chk("reset measId", measId, 0);
        chk("reset measValid", measValid, 0);
        chk("reset measTimeout", measTimeout, 0);
        chk("reset measSat", measSat, 0);
        chk("reset busy", busy, 0);
        resetN = 1'b1;
        repeat (2) @(negedge clock);

        // start with an empty mask must be ignored
        enMask = '0;
        start  = 1'b1;
        @(negedge clock);
        start = 1'b0;
        repeat (3) @(negedge clock);
        chk("empty mask ignored", busy, 0);

        for (int i = 0; i < N; i++) dly_cfg[i] = $urandom_range(0, 8);
        run_sweep(4'b1111, "full sweep");

        for (int i = 0; i < N; i++) len_cfg[i] = $urandom_range(5, 200);
        trig_seen = '0;
        run_sweep(4'b0101, "mask 0101");
        chk("mask 0101 untouched triggers", trig_seen & 4'b1010, 0);

        // channel 1 silent, plus a start pulse while busy that must be ignored
        len_cfg[1] = 0;
        got.delete();
        do_start(4'b1111, "timeout sweep");
        wait_strobes(1, 2000, "timeout sweep");
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        wait_idle(10000, "timeout sweep");
        check_results(4'b1111, 1, "timeout sweep");

        len_cfg[0] = 400;
        run_sweep(4'b0001, "saturation");

        for (int s = 0; s < 3; s++) begin
            logic [N-1:0] m;
            int           r;
            m = N'($urandom_range(1, (1 << N) - 1));
            for (int i = 0; i < N; i++) begin
                r          = $urandom_range(0, 9);
                len_cfg[i] = (r == 0) ? 0 : (r == 1) ? $urandom_range(260, 350) : $urandom_range(1, 250);
                dly_cfg[i] = $urandom_range(0, 8);
            end
            run_sweep(m, $sformatf("random sweep %0d", s));
        end

        for (int i = 0; i < N; i++) len_cfg[i] = $urandom_range(3, 120);
        continuous = 1'b1;
        got.delete();
        do_start(4'b1111, "continuous");
        wait_strobes(8, 20000, "continuous");
        continuous = 1'b0;
        wait_idle(10000, "continuous");
        check_results(4'b1111, 2, "continuous");

        // asynchronous reset in the middle of a measurement
        len_cfg[0] = 200;
        got.delete();
        do_start(4'b0001, "reset mid");
        begin
            int n;
            n = 0;
            while (!echo_hi[0] && n < 200) begin
                @(negedge clock);
                n++;
            end
        end
        repeat (20) @(negedge clock);
        chk("reset mid busy before", busy, 1);
        #1 resetN = 1'b0;
        #1;
        chk("async reset sTrigger", sTrigger, 0);
        chk("async reset meas", meas, 0);
        chk("async reset measId", measId, 0);
        chk("async reset measValid", measValid, 0);
        chk("async reset measTimeout", measTimeout, 0);
        chk("async reset measSat", measSat, 0);
        chk("async reset busy", busy, 0);
        repeat (2) @(negedge clock);
        resetN = 1'b1;
        @(negedge clock);
        len_cfg[0] = 37;
        run_sweep(4'b0001, "after reset");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
